mips_ctrl_core: RTL and testbench
=================================

// Module: mips_ctrl_core
// PURPOSE
//  Control/execute core of the multi-cycle Avalon MIPS CPU: instruction register, decoder and ALU (with HI/LO) in one block.
//  Latches the fetched word, decodes it per state into datapath/bus controls, and computes alu_result and the branch flag.
//  PC, register file, sign extension, state sequencing and operand muxes are outside this block.
// PARAMETERS
//  none
// PORTS
//  clk          in   1   system clock, all state updates on rising edge
//  rst          in   1   reset, asynchronous, active-low
//  state        in   2   00 FETCH, 01 EXEC, 10 MEM, 11 unused (treated as FETCH)
//  waitrequest  in   1   Avalon stall
//  mem_out      in   32  Avalon readdata
//  pc           in   32  current PC
//  alu_src_1    in   32  operand A (rs value or {27'b0,shamt})
//  alu_src_2    in   32  operand B (rt value or sign-extended imm)
//  instr        out  32  latched instruction (IR)
//  Halt         out  1   FETCH with pc==0
//  Extra        out  1   request MEM state after EXEC
//  MemRead      out  1   bus read
//  MemWrite     out  1   bus write
//  ByteEn       out  4   byteenable
//  MemSrc       out  1   1: address=pc, 0: address=alu_result
//  RegWrite     out  1   register file write enable
//  RegSrc       out  1   write addr: 1 rt, 0 rd (JAL forces via RegData=01, dest $31 outside)
//  RegData      out  2   00 mem_out, 01 pc, 10 alu_result
//  ALUSrc1      out  1   1: shamt, 0: rs
//  ALUSrc2      out  1   1: imm, 0: rt
//  PCControl    out  2   00 pc+4, 01 branch offset, 10 jump target, 11 rs
//  CntEn        out  1   PC advance enable
//  is_branch    out  1   conditional branch instruction
//  alu_result   out  32  ALU output
//  branch       out  1   branch condition true
// BEHAVIOUR
//  Reset (rst=0, async): instr=0, HI=0, LO=0; all outputs then follow combinationally from zeroed state.
//  IR: on clk edge, instr<=mem_out when state==FETCH and !waitrequest; otherwise holds.
//  FETCH: MemSrc=1, MemRead=1, ByteEn=1111, all writes/CntEn 0; Halt=1 if pc==0 (MemRead still 1).
//  EXEC: decode instr. Non-memory ops: RegWrite per op, CntEn=1, Extra=0, single cycle.
//   LW/SW: Extra=1, CntEn=0, RegWrite=0, ALU computes rs+imm.
//  MEM: MemSrc=0, ByteEn=1111; LW: MemRead=1, RegWrite=!waitrequest, RegSrc=1, RegData=00.
//   SW: MemWrite=1. CntEn=!waitrequest; signals held while waitrequest=1.
//  Supported: ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR JALR MULT MULTU DIV DIVU MFHI MFLO MTHI MTLO;
//   ADDIU SLTI SLTIU ANDI ORI XORI LUI LW SW BEQ BNE BLEZ BGTZ J JAL. Unknown opcode: no writes, CntEn=1 (NOP).
//  I-type ALU: ALUSrc2=1, RegSrc=1, RegData=10. ANDI/ORI/XORI zero-extend alu_src_2[15:0] inside ALU; LUI = {imm,16'b0}.
//  Shifts by shamt: ALUSrc1=1, operand B = rt; variable shifts use alu_src_1[4:0].
//  Arithmetic modulo 2^32, no overflow traps. SLT signed, SLTU/SLTIU unsigned (imm sign-extended first).
//  MULT/MULTU: {HI,LO}<=64-bit product at clk edge in EXEC. DIV/DIVU: LO<=quotient, HI<=remainder (signed: truncate toward 0).
//   Divide by zero: HI/LO unchanged. MTHI/MTLO write rs at EXEC edge; MFHI/MFLO output via alu_result, RegData=10.
//  branch: BEQ a==b, BNE a!=b, BLEZ signed a<=0, BGTZ signed a>0; else 0. Branches: is_branch=1, PCControl=01.
//  J: PCControl=10. JAL: PCControl=10, RegWrite=1, RegData=01. JR: PCControl=11. JALR: PCControl=11, RegWrite=1, RegData=01, RegSrc=0.
//  HI/LO write only in EXEC; never in FETCH/MEM.
// TESTING
//  Reset: rst=0 mid-EXEC -> instr=0, HI=LO=0 immediately; FETCH with pc=0 -> Halt=1.
//  IR: FETCH, mem_out=0x24020005, waitrequest=1 then 0 -> instr updates only on waitrequest=0 edge.
//  ADDIU $2,$0,5 in EXEC, a=0, b=5 -> alu_result=5, RegWrite=1, RegSrc=1, RegData=10, CntEn=1.
//  LW in EXEC -> Extra=1; MEM, waitrequest=1 two cycles -> RegWrite=0, CntEn=0; then waitrequest=0 -> RegWrite=1, CntEn=1.
//  MULT a=0xFFFFFFFF, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; DIV a=-7, b=2 -> LO=-3, HI=-1; DIV by 0 -> HI/LO held.
//  BNE a=3, b=3 -> branch=0, is_branch=1; BGTZ a=0x80000000 -> branch=0; SLTU a=1, b=0xFFFFFFFF -> 1.

Source files
------------

// File: rtl/mips_ctrl_core.sv
// Control/execute core of the multi-cycle MIPS CPU: instruction register, per-state decoder,
// and ALU with HI/LO multiply/divide registers. Control outputs are combinational from IR and state.
module mips_ctrl_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        waitrequest,
  input  logic [31:0] mem_out,
  input  logic [31:0] pc,
  input  logic [31:0] alu_src_1,
  input  logic [31:0] alu_src_2,
  output logic [31:0] instr,
  output logic        Halt,
  output logic        Extra,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  ByteEn,
  output logic        MemSrc,
  output logic        RegWrite,
  output logic        RegSrc,
  output logic [1:0]  RegData,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [1:0]  PCControl,
  output logic        CntEn,
  output logic        is_branch,
  output logic [31:0] alu_result,
  output logic        branch
);
  localparam logic [1:0] ST_EXEC = 2'b01, ST_MEM = 2'b10;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
    OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
    OP_LW = 6'h23, OP_SW = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09, FN_MFHI = 6'h10,
    FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19,
    FN_DIV = 6'h1A, FN_DIVU = 6'h1B, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
    FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic        fetch_st, exec_st, mem_st;
  logic [31:0] hi, lo;
  logic signed [31:0] a_s, b_s;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0] quo_u, rem_u;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign shamt    = alu_src_1[4:0];
  assign exec_st  = (state == ST_EXEC);
  assign mem_st   = (state == ST_MEM);
  assign fetch_st = !exec_st && !mem_st;
  assign a_s      = alu_src_1;
  assign b_s      = alu_src_2;

  assign prod_s = $signed({{32{alu_src_1[31]}}, alu_src_1}) * $signed({{32{alu_src_2[31]}}, alu_src_2});
  assign prod_u = {32'h0, alu_src_1} * {32'h0, alu_src_2};
  assign quo_s  = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quo_u  = alu_src_1 / alu_src_2;
  assign rem_u  = alu_src_1 % alu_src_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= '0;
    end else if (fetch_st && !waitrequest) begin
      instr <= mem_out;
    end
  end

  // HI/LO change only on the EXEC edge; divide by zero leaves both untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (exec_st && opcode == OP_R) begin
      case (funct)
        FN_MULT:  {hi, lo} <= prod_s;
        FN_MULTU: {hi, lo} <= prod_u;
        FN_DIV:   if (alu_src_2 != 32'h0) begin lo <= quo_s; hi <= rem_s; end
        FN_DIVU:  if (alu_src_2 != 32'h0) begin lo <= quo_u; hi <= rem_u; end
        FN_MTHI:  hi <= alu_src_1;
        FN_MTLO:  lo <= alu_src_1;
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU:         alu_result = alu_src_1 + alu_src_2;
          FN_SUBU:         alu_result = alu_src_1 - alu_src_2;
          FN_AND:          alu_result = alu_src_1 & alu_src_2;
          FN_OR:           alu_result = alu_src_1 | alu_src_2;
          FN_XOR:          alu_result = alu_src_1 ^ alu_src_2;
          FN_NOR:          alu_result = ~(alu_src_1 | alu_src_2);
          FN_SLT:          alu_result = {31'h0, a_s < b_s};
          FN_SLTU:         alu_result = {31'h0, alu_src_1 < alu_src_2};
          FN_SLL, FN_SLLV: alu_result = alu_src_2 << shamt;
          FN_SRL, FN_SRLV: alu_result = alu_src_2 >> shamt;
          FN_SRA, FN_SRAV: alu_result = $unsigned(b_s >>> shamt);
          FN_MFHI:         alu_result = hi;
          FN_MFLO:         alu_result = lo;
          default:         alu_result = '0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_result = alu_src_1 + alu_src_2;
      OP_SLTI:  alu_result = {31'h0, a_s < b_s};
      OP_SLTIU: alu_result = {31'h0, alu_src_1 < alu_src_2};
      OP_ANDI:  alu_result = alu_src_1 & {16'h0, alu_src_2[15:0]};
      OP_ORI:   alu_result = alu_src_1 | {16'h0, alu_src_2[15:0]};
      OP_XORI:  alu_result = alu_src_1 ^ {16'h0, alu_src_2[15:0]};
      OP_LUI:   alu_result = {alu_src_2[15:0], 16'h0};
      default:  alu_result = '0;
    endcase
  end

  always_comb begin
    branch = 1'b0;
    case (opcode)
      OP_BEQ:  branch = (alu_src_1 == alu_src_2);
      OP_BNE:  branch = (alu_src_1 != alu_src_2);
      OP_BLEZ: branch = (a_s <= 32'sd0);
      OP_BGTZ: branch = (a_s > 32'sd0);
      default: branch = 1'b0;
    endcase
  end

  always_comb begin
    Halt = 1'b0; Extra = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ByteEn = 4'h0;
    MemSrc = 1'b0; RegWrite = 1'b0; RegSrc = 1'b0; RegData = 2'b00; ALUSrc1 = 1'b0;
    ALUSrc2 = 1'b0; PCControl = 2'b00; CntEn = 1'b0; is_branch = 1'b0;
    if (fetch_st) begin
      MemSrc  = 1'b1;
      MemRead = 1'b1;
      ByteEn  = 4'hF;
      Halt    = (pc == 32'h0);
    end else if (exec_st) begin
      CntEn = 1'b1;
      case (opcode)
        OP_R: begin
          case (funct)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
            FN_SLLV, FN_SRLV, FN_SRAV, FN_MFHI, FN_MFLO: begin
              RegWrite = 1'b1;
              RegData  = 2'b10;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              RegWrite = 1'b1;
              RegData  = 2'b10;
              ALUSrc1  = 1'b1;
            end
            FN_JR:   PCControl = 2'b11;
            FN_JALR: begin PCControl = 2'b11; RegWrite = 1'b1; RegData = 2'b01; end
            default: ;
          endcase
        end
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          RegWrite = 1'b1;
          RegSrc   = 1'b1;
          RegData  = 2'b10;
          ALUSrc2  = 1'b1;
        end
        OP_LW, OP_SW: begin
          Extra   = 1'b1;
          CntEn   = 1'b0;
          ALUSrc2 = 1'b1;
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
          is_branch = 1'b1;
          PCControl = 2'b01;
        end
        OP_J:   PCControl = 2'b10;
        OP_JAL: begin PCControl = 2'b10; RegWrite = 1'b1; RegData = 2'b01; end
        default: ;
      endcase
    end else begin
      // MEM: address stays rs+imm while the bus stalls
      MemSrc  = 1'b0;
      ByteEn  = 4'hF;
      CntEn   = !waitrequest;
      ALUSrc2 = (opcode == OP_LW) || (opcode == OP_SW);
      if (opcode == OP_LW) begin
        MemRead  = 1'b1;
        RegWrite = !waitrequest;
        RegSrc   = 1'b1;
        RegData  = 2'b00;
      end else if (opcode == OP_SW) begin
        MemWrite = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mips_ctrl_core.sv
// Scoreboard bench for mips_ctrl_core: stimulus queues expected field values,
// a negedge monitor pops and compares them against the DUT.
module tb_mips_ctrl_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic        waitrequest;
  logic [31:0] mem_out, pc, alu_src_1, alu_src_2;
  logic [31:0] instr, alu_result;
  logic        Halt, Extra, MemRead, MemWrite, MemSrc, RegWrite, RegSrc, ALUSrc1, ALUSrc2;
  logic        CntEn, is_branch, branch;
  logic [3:0]  ByteEn;
  logic [1:0]  RegData, PCControl;

  typedef enum int {F_INSTR, F_HALT, F_EXTRA, F_MEMRD, F_MEMWR, F_RW, F_RSRC, F_RDATA,
                    F_SRC1, F_SRC2, F_PCC, F_CNT, F_ISBR, F_ALU, F_BR, F_MEMSRC} field_t;
  typedef struct {
    string       name;
    field_t      f;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  mips_ctrl_core dut (
    .clk(clk), .rst(rst), .state(state), .waitrequest(waitrequest), .mem_out(mem_out),
    .pc(pc), .alu_src_1(alu_src_1), .alu_src_2(alu_src_2), .instr(instr), .Halt(Halt),
    .Extra(Extra), .MemRead(MemRead), .MemWrite(MemWrite), .ByteEn(ByteEn), .MemSrc(MemSrc),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .RegData(RegData), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .PCControl(PCControl), .CntEn(CntEn), .is_branch(is_branch),
    .alu_result(alu_result), .branch(branch)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input field_t f);
    case (f)
      F_INSTR:  return instr;
      F_HALT:   return {31'h0, Halt};
      F_EXTRA:  return {31'h0, Extra};
      F_MEMRD:  return {31'h0, MemRead};
      F_MEMWR:  return {31'h0, MemWrite};
      F_RW:     return {31'h0, RegWrite};
      F_RSRC:   return {31'h0, RegSrc};
      F_RDATA:  return {30'h0, RegData};
      F_SRC1:   return {31'h0, ALUSrc1};
      F_SRC2:   return {31'h0, ALUSrc2};
      F_PCC:    return {30'h0, PCControl};
      F_CNT:    return {31'h0, CntEn};
      F_ISBR:   return {31'h0, is_branch};
      F_ALU:    return alu_result;
      F_BR:     return {31'h0, branch};
      F_MEMSRC: return {31'h0, MemSrc};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = actual(e.f);
        compared++;
        if (got !== e.exp) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input field_t f, input logic [31:0] v);
    exp_t e;
    e.name = name; e.f = f; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] word);
    state = 2'b00; mem_out = word; waitrequest = 1'b0;
    step();
    state = 2'b01;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; state = 2'b00; waitrequest = 1'b0; mem_out = 32'h24020005; pc = 32'h0;
    alu_src_1 = 32'h0; alu_src_2 = 32'h0;
    step();
    chk("reset_instr", F_INSTR, 32'h0);
    chk("reset_halt", F_HALT, 32'h1);
    chk("reset_memread", F_MEMRD, 32'h1);
    chk("fetch_memsrc", F_MEMSRC, 32'h1);
    step();
    rst = 1'b1; pc = 32'h100;

    waitrequest = 1'b1;
    step();
    chk("ir_hold_wait", F_INSTR, 32'h0);
    chk("halt_pc_nz", F_HALT, 32'h0);
    waitrequest = 1'b0;
    step();
    chk("ir_latch", F_INSTR, 32'h24020005);
    step();

    state = 2'b01; alu_src_1 = 32'h0; alu_src_2 = 32'h5;
    chk("addiu_alu", F_ALU, 32'h5);
    chk("addiu_rw", F_RW, 32'h1);
    chk("addiu_rsrc", F_RSRC, 32'h1);
    chk("addiu_rdata", F_RDATA, 32'h2);
    chk("addiu_cnt", F_CNT, 32'h1);
    chk("addiu_extra", F_EXTRA, 32'h0);
    chk("addiu_src2", F_SRC2, 32'h1);
    step();

    load(32'h00220018); alu_src_1 = 32'hFFFFFFFF; alu_src_2 = 32'h2;
    chk("mult_rw", F_RW, 32'h0);
    step();
    load(32'h00001010);
    chk("mult_hi", F_ALU, 32'hFFFFFFFF);
    chk("mfhi_rdata", F_RDATA, 32'h2);
    step();
    load(32'h00001012);
    chk("mult_lo", F_ALU, 32'hFFFFFFFE);
    step();

    load(32'h0022001A); alu_src_1 = 32'hFFFFFFF9; alu_src_2 = 32'h2;
    step();
    load(32'h00001012);
    chk("div_lo", F_ALU, 32'hFFFFFFFD);
    step();
    load(32'h00001010);
    chk("div_hi", F_ALU, 32'hFFFFFFFF);
    step();
    load(32'h0022001A); alu_src_1 = 32'd100; alu_src_2 = 32'h0;
    step();
    load(32'h00001012);
    chk("div0_lo_held", F_ALU, 32'hFFFFFFFD);
    step();
    load(32'h00001010);
    chk("div0_hi_held", F_ALU, 32'hFFFFFFFF);
    step();

    load(32'h8C430004); alu_src_1 = 32'h1000; alu_src_2 = 32'h4;
    chk("lw_addr", F_ALU, 32'h1004);
    chk("lw_extra", F_EXTRA, 32'h1);
    chk("lw_exec_cnt", F_CNT, 32'h0);
    chk("lw_exec_rw", F_RW, 32'h0);
    step();
    state = 2'b10; waitrequest = 1'b1;
    chk("lw_mem_rd", F_MEMRD, 32'h1);
    chk("lw_stall1_rw", F_RW, 32'h0);
    chk("lw_stall1_cnt", F_CNT, 32'h0);
    chk("lw_mem_memsrc", F_MEMSRC, 32'h0);
    step();
    chk("lw_stall2_rw", F_RW, 32'h0);
    chk("lw_stall2_cnt", F_CNT, 32'h0);
    chk("lw_stall2_instr", F_INSTR, 32'h8C430004);
    step();
    waitrequest = 1'b0;
    chk("lw_done_rw", F_RW, 32'h1);
    chk("lw_done_cnt", F_CNT, 32'h1);
    chk("lw_done_rdata", F_RDATA, 32'h0);
    chk("lw_done_rsrc", F_RSRC, 32'h1);
    chk("lw_done_addr", F_ALU, 32'h1004);
    step();

    load(32'hAC430004); state = 2'b10;
    chk("sw_memwr", F_MEMWR, 32'h1);
    chk("sw_memrd", F_MEMRD, 32'h0);
    chk("sw_rw", F_RW, 32'h0);
    step();

    load(32'h14220003); alu_src_1 = 32'h3; alu_src_2 = 32'h3;
    chk("bne_eq_br", F_BR, 32'h0);
    chk("bne_isbr", F_ISBR, 32'h1);
    chk("bne_pcc", F_PCC, 32'h1);
    step();
    alu_src_2 = 32'h4;
    chk("bne_ne_br", F_BR, 32'h1);
    step();
    load(32'h1C200002); alu_src_1 = 32'h80000000;
    chk("bgtz_neg", F_BR, 32'h0);
    step();
    alu_src_1 = 32'h1;
    chk("bgtz_pos", F_BR, 32'h1);
    step();

    load(32'h0022182B); alu_src_1 = 32'h1; alu_src_2 = 32'hFFFFFFFF;
    chk("sltu", F_ALU, 32'h1);
    step();
    load(32'h0022182A);
    chk("slt", F_ALU, 32'h0);
    step();
    load(32'h00021903); alu_src_1 = 32'h4; alu_src_2 = 32'h80000000;
    chk("sra", F_ALU, 32'hF8000000);
    chk("sra_src1", F_SRC1, 32'h1);
    step();
    load(32'h3C011234); alu_src_1 = 32'h0; alu_src_2 = 32'h1234;
    chk("lui", F_ALU, 32'h12340000);
    step();
    load(32'h3022FFFF); alu_src_1 = 32'hFFFFFFFF; alu_src_2 = 32'hFFFFFFFF;
    chk("andi_zext", F_ALU, 32'h0000FFFF);
    step();
    load(32'h0C000010);
    chk("jal_pcc", F_PCC, 32'h2);
    chk("jal_rw", F_RW, 32'h1);
    chk("jal_rdata", F_RDATA, 32'h1);
    step();
    load(32'hFC000000);
    chk("nop_cnt", F_CNT, 32'h1);
    chk("nop_rw", F_RW, 32'h0);
    chk("nop_memwr", F_MEMWR, 32'h0);
    step();

    load(32'h00220018); alu_src_1 = 32'hFFFFFFFF; alu_src_2 = 32'h2;
    step();
    load(32'h00001010);
    chk("pre_reset_hi", F_ALU, 32'hFFFFFFFF);
    step();
    rst = 1'b0;
    #1;
    chk("async_reset_instr", F_INSTR, 32'h0);
    step();
    state = 2'b00; pc = 32'h0;
    chk("reset_fetch_halt", F_HALT, 32'h1);
    step();
    rst = 1'b1; pc = 32'h200;
    load(32'h00001010);
    chk("reset_hi_zero", F_ALU, 32'h0);
    step();
    load(32'h00001012);
    chk("reset_lo_zero", F_ALU, 32'h0);
    step();

    step();
    step();
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
